// File: rtl/miriscv_dbus_pkg.sv
// -----------------------------------------------------------------------------
// miriscv_dbus_pkg
// Shared types and constants for the MIRISCV data-bus AXI4-Lite bridge:
//   - state_t     : bridge FSM state encoding
//   - AXI_RESP_OKAY : the only response treated as success
//   - sb_entry_t  : one store-buffer entry (word-aligned address, strobes, data)
// -----------------------------------------------------------------------------
package miriscv_dbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,  // AW and/or W still waiting for their handshake
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [31:0] addr;   // always word aligned, bits [1:0] are zero
    logic [3:0]  be;
    logic [31:0] wdata;
  } sb_entry_t;

endpackage

// File: rtl/miriscv_dbus_sb.sv
// -----------------------------------------------------------------------------
// miriscv_dbus_sb
// Synchronous FIFO used as the store buffer of the data-bus bridge.
// Ports:
//   clk_i, rst_n     : clock, synchronous active-low reset
//   push_i, entry_i  : write one entry (ignored while full)
//   pop_i            : drop the head entry (ignored while empty)
//   head_o           : current head entry, valid while !empty_o
//   full_o, empty_o  : status flags
//   count_o          : number of stored entries, 0..DEPTH
// A push and a pop in the same cycle leave the count unchanged.
// -----------------------------------------------------------------------------
module miriscv_dbus_sb
  import miriscv_dbus_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push_i,
  input  sb_entry_t        entry_i,
  input  logic             pop_i,
  output sb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  sb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage has no reset so it can map onto plain memory; the pointers and
  // count alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/miriscv_dbus_axil_bridge.sv
// -----------------------------------------------------------------------------
// miriscv_dbus_axil_bridge
// Bridges the MIRISCV LSU data port onto an AXI4-Lite master.
// Stores are posted into a small store buffer; loads block the LSU until the
// read data returns. Only one AXI transaction is outstanding at any time and
// buffered stores always drain before a load is issued, so loads always see
// older stores.
// Ports:
//   clk_i, rst_n        : clock, synchronous active-low reset
//   data_req_i/we_i/be_i/addr_i/wdata_i : LSU request
//   data_rvalid_o, data_rdata_o         : load response (raw 32-bit word)
//   dbus_stall_o        : store buffer full, core must stall
//   bus_err_o           : one-cycle pulse on error response or dropped store
//   axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r* : AXI4-Lite master channels
// -----------------------------------------------------------------------------
module miriscv_dbus_axil_bridge
  import miriscv_dbus_pkg::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  // LSU side
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        dbus_stall_o,
  output logic        bus_err_o,
  // AXI4-Lite write address
  output logic        axi_awvalid_o,
  input  logic        axi_awready_i,
  output logic [31:0] axi_awaddr_o,
  output logic [2:0]  axi_awprot_o,
  // AXI4-Lite write data
  output logic        axi_wvalid_o,
  input  logic        axi_wready_i,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  // AXI4-Lite write response
  input  logic        axi_bvalid_i,
  output logic        axi_bready_o,
  input  logic [1:0]  axi_bresp_i,
  // AXI4-Lite read address
  output logic        axi_arvalid_o,
  input  logic        axi_arready_i,
  output logic [31:0] axi_araddr_o,
  output logic [2:0]  axi_arprot_o,
  // AXI4-Lite read data
  input  logic        axi_rvalid_i,
  output logic        axi_rready_o,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  state_t      state_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        arvalid_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] araddr_q;
  logic        load_pending_q;
  logic [31:0] load_addr_q;
  logic        data_rvalid_q;
  logic [31:0] data_rdata_q;
  logic        bus_err_q;

  sb_entry_t        new_entry;
  sb_entry_t        sb_head;
  sb_entry_t        launch_entry;
  logic             sb_full;
  logic             sb_empty;
  logic [CNT_W-1:0] sb_count;

  logic        idle;
  logic        store_req;
  logic        store_acc;
  logic        store_drop;
  logic        load_acc;
  logic        bypass;
  logic        sb_push;
  logic        sb_pop;
  logic        load_go;
  logic [31:0] load_addr;
  logic        aw_done;
  logic        w_done;
  logic        unused_addr_lsb;

  // Byte offset is carried by the strobes; the bus only sees word addresses.
  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign new_entry.addr  = {data_addr_i[31:2], 2'b00};
  assign new_entry.be    = data_be_i;
  assign new_entry.wdata = data_wdata_i;

  assign idle       = (state_q == S_IDLE);
  assign store_req  = data_req_i & data_we_i;
  assign store_acc  = store_req & ~sb_full;
  assign store_drop = store_req & sb_full;

  // The LSU keeps its load request up through the rvalid cycle, so both the
  // pending flag and the response pulse block a fresh acceptance.
  assign load_acc = data_req_i & ~data_we_i & ~load_pending_q & ~data_rvalid_q;

  // With an idle bus and an empty buffer an incoming store goes straight to
  // AW/W instead of taking a trip through the FIFO; this gives the
  // one-cycle push-to-handshake cost.
  assign bypass  = idle & sb_empty & store_acc;
  assign sb_push = store_acc & ~bypass;
  assign sb_pop  = idle & ~sb_empty;
  assign launch_entry = sb_empty ? new_entry : sb_head;

  // A load may only start when nothing older is buffered, in flight, or
  // arriving this very cycle. A load accepted this cycle is launched at once.
  assign load_go   = idle & sb_empty & ~store_acc & (load_pending_q | load_acc);
  assign load_addr = load_pending_q ? load_addr_q : {data_addr_i[31:2], 2'b00};

  assign aw_done = ~awvalid_q | axi_awready_i;
  assign w_done  = ~wvalid_q | axi_wready_i;

  miriscv_dbus_sb #(
    .DEPTH (SB_DEPTH)
  ) u_sb (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (sb_push),
    .entry_i (new_entry),
    .pop_i   (sb_pop),
    .head_o  (sb_head),
    .full_o  (sb_full),
    .empty_o (sb_empty),
    .count_o (sb_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      araddr_q       <= '0;
      load_pending_q <= 1'b0;
      load_addr_q    <= '0;
      data_rvalid_q  <= 1'b0;
      data_rdata_q   <= '0;
      bus_err_q      <= 1'b0;
    end else begin
      data_rvalid_q <= 1'b0;
      bus_err_q     <= store_drop;

      if (load_acc) begin
        load_pending_q <= 1'b1;
        load_addr_q    <= {data_addr_i[31:2], 2'b00};
      end

      case (state_q)
        S_IDLE: begin
          if (bypass || sb_pop) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= launch_entry.addr;
            wdata_q   <= launch_entry.wdata;
            wstrb_q   <= launch_entry.be;
            state_q   <= S_WADDR;
          end else if (load_go) begin
            arvalid_q <= 1'b1;
            araddr_q  <= load_addr;
            state_q   <= S_RADDR;
          end
        end

        S_WADDR: begin
          if (axi_awready_i) awvalid_q <= 1'b0;
          if (axi_wready_i)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state_q <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (axi_bvalid_i) begin
            state_q <= S_IDLE;
            if (axi_bresp_i != AXI_RESP_OKAY) bus_err_q <= 1'b1;
          end
        end

        S_RADDR: begin
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            state_q   <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (axi_rvalid_i) begin
            data_rdata_q   <= axi_rdata_i;
            data_rvalid_q  <= 1'b1;
            load_pending_q <= 1'b0;
            state_q        <= S_IDLE;
            if (axi_rresp_i != AXI_RESP_OKAY) bus_err_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbus_stall_o  = (sb_count == CNT_W'(SB_DEPTH));
  assign bus_err_o     = bus_err_q;
  assign data_rvalid_o = data_rvalid_q;
  assign data_rdata_o  = data_rdata_q;

  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = awaddr_q;
  assign axi_awprot_o  = 3'b000;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_bready_o  = (state_q == S_WRESP);
  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = araddr_q;
  assign axi_arprot_o  = 3'b000;
  assign axi_rready_o  = (state_q == S_RDATA);

endmodule
